// File: rtl/image_frame_loader.sv
// Packs a one-pixel-per-beat stream into a flat, MSB-first frame bus.
// The finished frame is held until the consumer acknowledges it.
module image_frame_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [0:D*H*W*DATA_WIDTH-1]      image,
    output logic                             image_valid,
    input  logic                             image_ack,
    output logic [15:0]                      fill_count,
    output logic                             frame_err
);
    localparam int NPIX = D * H * W;
    localparam int CW   = (W > 1) ? $clog2(W) : 1;
    localparam int RW   = (H > 1) ? $clog2(H) : 1;
    localparam int PW   = (D > 1) ? $clog2(D) : 1;

    typedef enum logic {FILL, FULL} state_t;

    state_t          state_q;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   ch_q, ch_d;
    logic [15:0]     fill_q;
    logic            in_ready_q;
    logic            image_valid_q;
    logic            frame_err_q;
    logic            beat;
    logic            final_pix;
    logic            col_wrap, row_wrap, ch_wrap;

    assign beat     = in_valid & in_ready_q;
    assign col_wrap = (col_q == CW'(W - 1));
    assign row_wrap = (row_q == RW'(H - 1));
    assign ch_wrap  = (ch_q  == PW'(D - 1));
    assign final_pix = col_wrap & row_wrap & ch_wrap;

    // Raster advance: col carries into row, row carries into ch.
    always_comb begin
        col_d = col_q + CW'(1);
        row_d = row_q;
        ch_d  = ch_q;
        if (col_wrap) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (row_wrap) begin
                row_d = '0;
                ch_d  = ch_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FILL;
            col_q         <= '0;
            row_q         <= '0;
            ch_q          <= '0;
            fill_q        <= '0;
            in_ready_q    <= 1'b1;
            image_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (beat) begin
                        if (final_pix) begin
                            // fill_count keeps showing the full frame size while held.
                            state_q       <= FULL;
                            in_ready_q    <= 1'b0;
                            image_valid_q <= 1'b1;
                            fill_q        <= fill_q + 16'd1;
                            col_q         <= '0;
                            row_q         <= '0;
                            ch_q          <= '0;
                            if (!in_last) frame_err_q <= 1'b1;
                        end else if (in_last) begin
                            col_q       <= '0;
                            row_q       <= '0;
                            ch_q        <= '0;
                            fill_q      <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            col_q  <= col_d;
                            row_q  <= row_d;
                            ch_q   <= ch_d;
                            fill_q <= fill_q + 16'd1;
                        end
                    end
                end
                FULL: begin
                    if (image_ack) begin
                        state_q       <= FILL;
                        in_ready_q    <= 1'b1;
                        image_valid_q <= 1'b0;
                        fill_q        <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    // One register per pixel slot, written in place when its index comes up.
    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_pix
            logic [DATA_WIDTH-1:0] pix_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    pix_q <= '0;
                else if (beat && fill_q == 16'(gi))
                    pix_q <= in_data;
            end
            assign image[gi*DATA_WIDTH +: DATA_WIDTH] = pix_q;
        end
    endgenerate

    assign in_ready    = in_ready_q;
    assign image_valid = image_valid_q;
    assign fill_count  = fill_q;
    assign frame_err   = frame_err_q;

endmodule

// File: doc/image_frame_loader.md
# image_frame_loader

Stream-to-frame writer on the input side of the convolution layer. Accepts pixels one per beat over a valid/ready handshake and packs them into the flat, MSB-first `image` bus the conv layer reads. When a full D×H×W frame is assembled, it holds the frame stable, asserts `image_valid`, and waits for the consumer's `image_ack` before accepting the next frame. It also checks frame framing against an end-of-frame marker.

## Interface

Parameters:
- `DATA_WIDTH`, 16: pixel width in bits.
- `D`, 1: image depth (channels).
- `H`, 32: image height.
- `W`, 32: image width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset (asserted at 0).
- `in_data`, input, DATA_WIDTH: pixel value.
- `in_valid`, input, 1: `in_data` and `in_last` are valid.
- `in_last`, input, 1: the producer marks this beat as the final pixel of its frame.
- `in_ready`, output, 1: loader can accept a beat.
- `image`, output, [0:D*H*W*DATA_WIDTH-1]: assembled frame, same layout as the conv layer's image input.
- `image_valid`, output, 1: `image` holds a complete frame.
- `image_ack`, input, 1: consumer has finished with `image`.
- `fill_count`, output, 16: number of pixels accepted in the current frame.
- `frame_err`, output, 1: sticky framing-error flag.

## Operation

- A beat transfers on a rising edge when `in_valid` and `in_ready` are both 1.
- Pixel ordering is raster, with depth outermost:
  - Pixel index k = ch*H*W + row*W + col.
  - Pixel k is written to `image[k*DATA_WIDTH +: DATA_WIDTH]`, so pixel 0 occupies bits [0:DATA_WIDTH-1].
- Internal counters `col`, `row`, `ch` increment on each beat:
  - `col` wraps at W-1 and carries into `row`.
  - `row` wraps at H-1 and carries into `ch`.
  - `fill_count` equals k of the next expected pixel.
- States:
  - FILL: `in_ready`=1, `image_valid`=0.
    - A beat with k = D*H*W-1 moves to FULL.
    - An early `in_last` (k < D*H*W-1) is a resync event: the beat is written, then the counters clear to 0, `frame_err` sets, and the state stays FILL.
  - FULL: `in_ready`=0, `image_valid`=1, `image` stable.
    - `image_ack`=1 moves to FILL with counters at 0.
- Final-beat framing check: if `in_last`=0 on the final beat (k = D*H*W-1), the frame still completes and `frame_err` sets.
- `image_ack` is ignored in FILL.
- `image` is never cleared between frames. Pixels are overwritten in place as the new frame streams in.
- `frame_err` clears only on reset.
- Reset values:
  - state FILL, all counters 0, `fill_count`=0.
  - `image` all zeros, `image_valid`=0, `in_ready`=1, `frame_err`=0.
- Reset mid-frame or while FULL discards the partial or held frame immediately, asynchronously.

## Timing

- `in_ready` and `image_valid` are decoded from registered state only. There is no combinational path from the inputs to the outputs.
- Sustained throughput is one pixel per cycle in FILL.
- Final-beat latency: the final beat is accepted at edge N; `image_valid`=1 and `in_ready`=0 from edge N on (visible during cycle N+1).
- Ack turnaround: `image_ack` sampled 1 at edge M gives `image_valid`=0 and `in_ready`=1 after edge M. The first pixel of the next frame can transfer at edge M+1.
- Minimum frame period is D*H*W+1 cycles.
- Simultaneous events:
  - `in_valid` during FULL: no transfer, data is held by the producer.
  - `image_ack` on the same edge as a final beat: ignored, because the state was FILL at that edge.
- `fill_count` updates on the same edge as the beat that caused it.

## Test plan

Unless stated otherwise, parameters are D=1, H=4, W=4, DATA_WIDTH=16.

- **Reset:** drive `reset`=0 mid-stream. Required: `in_ready`=1, `image_valid`=0, `fill_count`=0, `image`=0, `frame_err`=0, all asynchronously without waiting for a clock edge.
- **Full frame:** stream 16 beats with `in_data`=k+1 and `in_last` on beat 15. Required:
  - `image_valid`=1 one cycle after beat 15.
  - `image[0:15]`=1 and `image[240:255]`=16.
  - `in_ready`=0 until `image_ack` is given.
- **Backpressure and ack:** hold `in_valid`=1 during FULL for 5 cycles, then pulse `image_ack`. Required:
  - No beats accepted during FULL.
  - `fill_count` stays 16.
  - The next frame's first beat is accepted the cycle after the ack edge and lands at `image[0:15]`.
- **Gapped input:** toggle `in_valid` randomly at 50%. Required: the frame contents are identical to the gap-free case, and `fill_count` increments only on transfers.
- **Early `in_last`:** assert `in_last` on beat 9. Required: `frame_err`=1, `fill_count` returns to 0, `image_valid` stays 0. The next 16-beat frame then completes correctly with `frame_err` still 1.
- **Depth ordering and missing `in_last`:** use D=2, H=2, W=3 with no `in_last`. Required: pixel 6 lands at bits [96:111], `image_valid` asserts after 12 beats, and `frame_err`=1.
